// File: rtl/instrmem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instrmem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_COLLECT,
    ST_WR_LO,
    ST_WR_HI,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] WE_LO     = 4'b0011;
  localparam logic [3:0] WE_HI     = 4'b1100;
  localparam int         LEN_BYTES = 2;

endpackage

// File: rtl/instrmem_loader_byte_packer.sv
// byte_packer: assembles four consecutive bytes into one little-endian word
// (first byte lands in bits 7:0) and pulses o_word_valid once the word is complete.
module byte_packer #(
  parameter int NB_BYTE = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [NB_BYTE-1:0]     i_byte,
  output logic                   o_last,
  output logic [4*NB_BYTE-1:0]   o_word,
  output logic                   o_word_valid
);

  logic [1:0] r_cnt;
  logic       r_word_valid;

  assign o_last       = i_valid && (r_cnt == 2'd3);
  assign o_word_valid = r_word_valid;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= o_last;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_valid) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // One lane register per byte position; the counter selects which lane loads.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [NB_BYTE-1:0] r_lane;

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        r_lane <= '0;
      end else if (i_valid && (r_cnt == 2'(gi))) begin
        r_lane <= i_byte;
      end
    end

    assign o_word[gi*NB_BYTE +: NB_BYTE] = r_lane;
  end

endmodule

// File: rtl/instrmem_loader.sv
// instrmem_loader: receives a length-prefixed byte stream and writes it as halfwords
// into the instruction-memory debug port. Optional trailing XOR checksum: INSTRMEM_LOADER_CHECKSUM_EN.
module instrmem_loader
  import instrmem_loader_pkg::*;
#(
  parameter int N_ADDR      = 2048,
  parameter int NB_BYTE     = 8,
  parameter int NB_DBG_ADDR = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [NB_BYTE-1:0]     i_byte,
  input  logic                   i_byte_valid,
  output logic                   o_byte_ready,
  output logic [NB_DBG_ADDR-1:0] o_debug_instrmem_addr,
  output logic [15:0]            o_debug_instrmem_data,
  output logic [3:0]             o_debug_instrmem_we,
  output logic                   o_debug_instrmem_re,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [NB_DBG_ADDR-1:0] o_words
);

`ifdef INSTRMEM_LOADER_CHECKSUM_EN
  localparam state_t LP_ST_END = ST_CHECK;
`else
  localparam state_t LP_ST_END = ST_DONE;
`endif

  state_t                   r_state;
  state_t                   w_state_next;
  logic [LEN_BYTES*8-1:0]   r_len;
  logic [LEN_BYTES*8-1:0]   w_len_full;
  logic [NB_DBG_ADDR-1:0]   r_words;
  logic [NB_DBG_ADDR-1:0]   w_words_inc;
  logic [NB_BYTE-1:0]       r_csum;
  logic                     r_error;
  logic                     w_hs;
  logic                     w_start_ok;
  logic                     w_len_zero;
  logic                     w_len_over;
  logic                     w_more;
  logic                     w_pack_valid;
  logic                     w_pack_last;
  logic                     w_word_valid;
  logic [4*NB_BYTE-1:0]     w_word;

  assign o_byte_ready = r_state inside {ST_LEN_LO, ST_LEN_HI, ST_COLLECT, ST_CHECK};
  assign w_hs         = i_byte_valid && o_byte_ready;
  assign w_start_ok   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pack_valid = w_hs && (r_state == ST_COLLECT);

  assign w_len_full  = {i_byte[7:0], r_len[7:0]};
  assign w_len_zero  = (w_len_full == '0);
  assign w_len_over  = 32'(w_len_full) > 32'(N_ADDR);
  assign w_words_inc = r_words + NB_DBG_ADDR'(1);
  assign w_more      = 32'(w_words_inc) < 32'(r_len);

  assign o_busy                = !((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign o_done                = (r_state == ST_DONE);
  assign o_error               = r_error;
  assign o_words               = r_words;
  assign o_debug_instrmem_addr = r_words;
  assign o_debug_instrmem_re   = 1'b0;

  byte_packer #(
    .NB_BYTE (NB_BYTE)
  ) u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_start_ok),
    .i_valid      (w_pack_valid),
    .i_byte       (i_byte),
    .o_last       (w_pack_last),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_words <= '0;
      r_csum  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_len   <= '0;
        r_words <= '0;
        r_csum  <= '0;
        r_error <= 1'b0;
      end
      if ((r_state == ST_LEN_LO) && w_hs) begin
        r_len[7:0] <= i_byte[7:0];
      end
      // An oversized length aborts before any write, so the address stays below N_ADDR.
      if ((r_state == ST_LEN_HI) && w_hs) begin
        r_len <= w_len_full;
        if (w_len_over) begin
          r_error <= 1'b1;
        end
      end
      if (w_pack_valid) begin
        r_csum <= r_csum ^ i_byte;
      end
      if (r_state == ST_WR_HI) begin
        r_words <= w_words_inc;
      end
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
      if ((r_state == ST_CHECK) && w_hs) begin
        r_error <= (i_byte != r_csum);
      end
`endif
    end
  end

  always_comb begin
    w_state_next          = r_state;
    o_debug_instrmem_we   = 4'b0000;
    o_debug_instrmem_data = 16'h0000;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) w_state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_hs) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_hs) begin
          if (w_len_zero)      w_state_next = LP_ST_END;
          else if (w_len_over) w_state_next = ST_DONE;
          else                 w_state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_pack_last) w_state_next = ST_WR_LO;
      end
      ST_WR_LO: begin
        o_debug_instrmem_we   = w_word_valid ? WE_LO : 4'b0000;
        o_debug_instrmem_data = w_word[15:0];
        w_state_next          = ST_WR_HI;
      end
      ST_WR_HI: begin
        o_debug_instrmem_we   = WE_HI;
        o_debug_instrmem_data = w_word[31:16];
        w_state_next          = w_more ? ST_COLLECT : LP_ST_END;
      end
      ST_CHECK: begin
        if (w_hs) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instrmem_loader.sv
// Scoreboard bench for instrmem_loader: stimulus pushes expected writes/status,
// a negedge monitor pops and compares whenever the DUT writes or raises o_done.
module tb_instrmem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic [15:0] o_debug_instrmem_addr;
  logic [15:0] o_debug_instrmem_data;
  logic [3:0]  o_debug_instrmem_we;
  logic        o_debug_instrmem_re;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words;

  always #5 clk = ~clk;

  instrmem_loader #(
    .N_ADDR      (2048),
    .NB_BYTE     (8),
    .NB_DBG_ADDR (16)
  ) dut (
    .i_clock               (clk),
    .i_reset               (rst_n),
    .i_start               (i_start),
    .i_byte                (i_byte),
    .i_byte_valid          (i_byte_valid),
    .o_byte_ready          (o_byte_ready),
    .o_debug_instrmem_addr (o_debug_instrmem_addr),
    .o_debug_instrmem_data (o_debug_instrmem_data),
    .o_debug_instrmem_we   (o_debug_instrmem_we),
    .o_debug_instrmem_re   (o_debug_instrmem_re),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_error               (o_error),
    .o_words               (o_words)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  we;
  } wr_t;

  typedef struct packed {
    logic        err;
    logic [15:0] words;
  } st_t;

  wr_t        exp_wr[$];
  st_t        exp_st[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] csum = 8'h00;
  logic       prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    st_t s;
    if (rst_n) begin
      if (o_debug_instrmem_we != 4'b0000) begin
        $display("WR addr=%0d data=0x%04h we=%b", o_debug_instrmem_addr,
                 o_debug_instrmem_data, o_debug_instrmem_we);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(o_debug_instrmem_we), 0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(o_debug_instrmem_addr), 32'(e.addr));
          chk("wr_data", 32'(o_debug_instrmem_data), 32'(e.data));
          chk("wr_we", 32'(o_debug_instrmem_we), 32'(e.we));
        end
      end
      if (o_done && !prev_done) begin
        $display("DONE error=%0b words=%0d", o_error, o_words);
        if (exp_st.size() == 0) begin
          chk("unexpected_done", 32'(o_done), 0);
        end else begin
          s = exp_st.pop_front();
          chk("done_error", 32'(o_error), 32'(s.err));
          chk("done_words", 32'(o_words), 32'(s.words));
        end
      end
    end
    prev_done <= o_done;
  end

  function automatic logic [7:0] byte_of(input int w, input int k);
    return 8'((w * 4 + k) * 37 + 5);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit hold, output int gap);
    i_byte       = b;
    i_byte_valid = 1'b1;
    gap          = 0;
    while (!o_byte_ready && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    if (!o_byte_ready) chk("ready_timeout", 32'(o_byte_ready), 1);
    @(posedge clk); #1;
    if (!hold) i_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic begin_load();
    csum = 8'h00;
    pulse_start();
  endtask

  task automatic send_len(input logic [15:0] n);
    int g;
    send_byte(n[7:0], 1'b0, g);
    send_byte(n[15:8], 1'b0, g);
  endtask

  // Sends nw words starting at word index first_w; glitch_at pulses i_start before that byte.
  task automatic send_payload(input int first_w, input int nw, input bit hold, input int glitch_at);
    int g;
    for (int w = first_w; w < first_w + nw; w++) begin
      logic [31:0] word;
      for (int k = 0; k < 4; k++) word[8*k +: 8] = byte_of(w, k);
      exp_wr.push_back({16'(w), word[15:0], 4'b0011});
      exp_wr.push_back({16'(w), word[31:16], 4'b1100});
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k == glitch_at) begin
          i_byte_valid = 1'b0;
          pulse_start();
          chk("start_ignored_busy", 32'(o_busy), 1);
          chk("start_ignored_words", 32'(o_words), 32'(w));
        end
        csum ^= word[8*k +: 8];
        send_byte(word[8*k +: 8], hold, g);
        chk("ready_gap", 32'(g), (k == 0 && w != first_w) ? 2 : 0);
      end
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic send_trailer();
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
    int g;
    send_byte(csum, 1'b0, g);
`endif
  endtask

  task automatic wait_done();
    int c = 0;
    while (!o_done && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (!o_done) chk("done_timeout", 32'(o_done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g;
    logic [7:0] b1 [4];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_byte_ready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_we", 32'(o_debug_instrmem_we), 0);
    chk("rst_addr", 32'(o_debug_instrmem_addr), 0);
    chk("rst_data", 32'(o_debug_instrmem_data), 0);
    chk("rst_words", 32'(o_words), 0);
    chk("rst_re", 32'(o_debug_instrmem_re), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=1, word 0x12345678
    b1[0] = 8'h78; b1[1] = 8'h56; b1[2] = 8'h34; b1[3] = 8'h12;
    exp_wr.push_back({16'd0, 16'h5678, 4'b0011});
    exp_wr.push_back({16'd0, 16'h1234, 4'b1100});
    exp_st.push_back({1'b0, 16'd1});
    begin_load();
    chk("start_busy", 32'(o_busy), 1);
    send_len(16'd1);
    for (int k = 0; k < 4; k++) begin
      csum ^= b1[k];
      send_byte(b1[k], 1'b0, g);
    end
    chk("wr_lo_latency", 32'(o_debug_instrmem_we), 32'(4'b0011));
    send_trailer();
    wait_done();

    // N=3 streamed with valid held high
    exp_st.push_back({1'b0, 16'd3});
    begin_load();
    chk("start_clears_done", 32'(o_done), 0);
    send_len(16'd3);
    send_payload(0, 3, 1'b1, -1);
    send_trailer();
    wait_done();

    // N=0x0801 exceeds depth: no writes, error
    exp_st.push_back({1'b1, 16'd0});
    begin_load();
    send_len(16'h0801);
    wait_done();

    // N=0: nothing written, no error
    exp_st.push_back({1'b0, 16'd0});
    begin_load();
    send_len(16'h0000);
    send_trailer();
    wait_done();

    // N=0x0800 is exactly the depth: accepted into COLLECT, then aborted by reset
    begin_load();
    send_len(16'h0800);
    chk("full_depth_busy", 32'(o_busy), 1);
    chk("full_depth_ready", 32'(o_byte_ready), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset during WR_HI of word 5, then reload from address 0
    begin_load();
    send_len(16'd8);
    send_payload(0, 5, 1'b1, -1);
    begin
      logic [31:0] word;
      for (int k = 0; k < 4; k++) word[8*k +: 8] = byte_of(5, k);
      exp_wr.push_back({16'd5, word[15:0], 4'b0011});
      for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], 1'b0, g);
    end
    @(posedge clk); #1;
    chk("wr_hi_we", 32'(o_debug_instrmem_we), 32'(4'b1100));
    chk("wr_hi_addr", 32'(o_debug_instrmem_addr), 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(o_debug_instrmem_we), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_words", 32'(o_words), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_st.push_back({1'b0, 16'd1});
    begin_load();
    send_len(16'd1);
    send_payload(0, 1, 1'b0, -1);
    send_trailer();
    wait_done();

    // i_start pulsed mid-COLLECT is ignored
    exp_st.push_back({1'b0, 16'd2});
    begin_load();
    send_len(16'd2);
    send_payload(0, 2, 1'b0, 6);
    send_trailer();
    wait_done();

`ifdef INSTRMEM_LOADER_CHECKSUM_EN
    // Checksum trailer: XOR of 11,22,33,44 is 0x44
    b1[0] = 8'h11; b1[1] = 8'h22; b1[2] = 8'h33; b1[3] = 8'h44;
    for (int t = 0; t < 2; t++) begin
      exp_wr.push_back({16'd0, 16'h2211, 4'b0011});
      exp_wr.push_back({16'd0, 16'h4433, 4'b1100});
      exp_st.push_back({(t == 1), 16'd1});
      begin_load();
      send_len(16'd1);
      for (int k = 0; k < 4; k++) send_byte(b1[k], 1'b0, g);
      send_byte((t == 0) ? 8'h44 : 8'h45, 1'b0, g);
      wait_done();
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("exp_wr_left", 32'(exp_wr.size()), 0);
    chk("exp_st_left", 32'(exp_st.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
